// File: rtl/ecc_secded_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_decoder_pipe
// Purpose  : Two-stage pipelined SEC-DED decoder between an SRAM read port and
//            a bus-side read buffer. Corrects any single-bit error, detects any
//            double-bit error, and keeps saturating CE/UE event counters.
// Ports    : clk, rst_n (async, active-low)
//            in_valid / in_ready / ddi [CW_W]       - codeword stream in
//            out_valid / out_ready / ddo [DATA_W]   - corrected data out
//            e1, e2, err_pos [PAR_W+1]              - per-word error flags
//            cnt_clr, ce_cnt [CNT_W], ue_cnt [CNT_W] - event counters
//            log_valid, log_type, log_synd          - first-error log
//                                                     (ECC_ERR_LOG_EN only)
// Config   : define ECC_ERR_LOG_EN to add the first-error capture log.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_secded_decoder_pipe #(
  parameter  int DATA_W = 32,
  parameter  int PAR_W  = 6,
  parameter  int CNT_W  = 16,
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   ddi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ddo,
  output logic              e1,
  output logic              e2,
  output logic [PAR_W:0]    err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt
`ifdef ECC_ERR_LOG_EN
  ,
  output logic              log_valid,
  output logic              log_type,
  output logic [PAR_W:0]    log_synd
`endif
);

  localparam logic [PAR_W:0] C_CW_W = (PAR_W+1)'(CW_W);

  // Codeword position of data bit j: the j-th non-power-of-two index >= 1.
  function automatic int data_pos(input int j);
    int n;
    int r;
    n = 0;
    r = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == j) r = p;
        n++;
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc,
                                                input logic clr);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr)
      nxt = {{(CNT_W-1){1'b0}}, inc};  // same-cycle event survives the clear
    else if (inc && (cur != '1))
      nxt = cur + CNT_W'(1);
    return nxt;
  endfunction

  // ---------------- handshake ----------------
  logic r_s1_valid;
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_load = !out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // ---------------- stage 1: syndrome ----------------
  logic [PAR_W-1:0] w_syn;
  logic             w_q;
  logic [CW_W-1:0]  r_s1_cw;
  logic [PAR_W-1:0] r_s1_syn;
  logic             r_s1_q;

  always_comb begin
    w_syn = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (ddi[i]) w_syn = w_syn ^ PAR_W'(i);
    end
  end

  assign w_q = ^ddi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_syn   <= '0;
      r_s1_q     <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw  <= ddi;
        r_s1_syn <= w_syn;
        r_s1_q   <= w_q;
      end
    end
  end

  // ---------------- classification and correction ----------------
  logic              w_e1;
  logic              w_e2;
  logic              w_syn_oob;
  logic [CW_W-1:0]   w_corr;
  logic [DATA_W-1:0] w_data;

  // A syndrome pointing past the codeword cannot be a single error.
  assign w_syn_oob = {1'b0, r_s1_syn} >= C_CW_W;
  assign w_e1      = r_s1_q && !w_syn_oob;
  assign w_e2      = (r_s1_q && w_syn_oob) || (!r_s1_q && (r_s1_syn != '0));

  // Syndrome 0 with q=1 flips the overall parity bit only, leaving data intact.
  always_comb begin
    w_corr = r_s1_cw;
    if (w_e1) w_corr[r_s1_syn] = ~r_s1_cw[r_s1_syn];
  end

  for (genvar j = 0; j < DATA_W; j++) begin : g_data
    assign w_data[j] = w_corr[data_pos(j)];
  end

  // ---------------- stage 2: output register ----------------
  logic w_s2_take;
  assign w_s2_take = w_s2_load && r_s1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ddo       <= '0;
      e1        <= 1'b0;
      e2        <= 1'b0;
      err_pos   <= '0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        ddo     <= w_data;
        e1      <= w_e1;
        e2      <= w_e2;
        err_pos <= w_e1 ? {1'b0, r_s1_syn} : '0;
      end
    end
  end

  // ---------------- event counters ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt <= '0;
      ue_cnt <= '0;
    end else begin
      ce_cnt <= cnt_next(ce_cnt, w_s2_take && w_e1, cnt_clr);
      ue_cnt <= cnt_next(ue_cnt, w_s2_take && w_e2, cnt_clr);
    end
  end

`ifdef ECC_ERR_LOG_EN
  // ---------------- first-error log ----------------
  logic w_err_in;
  assign w_err_in = w_s2_take && (w_e1 || w_e2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid <= 1'b0;
      log_type  <= 1'b0;
      log_synd  <= '0;
    end else if (w_err_in && (cnt_clr || !log_valid)) begin
      log_valid <= 1'b1;
      log_type  <= w_e2;
      log_synd  <= {r_s1_q, r_s1_syn};
    end else if (cnt_clr) begin
      log_valid <= 1'b0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ecc_secded_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_secded_decoder_pipe
// Purpose  : Scoreboard bench for ecc_secded_decoder_pipe. Codewords are built
//            by a reference encoder, faults are injected at known positions,
//            and the expected result follows from the number of injected flips.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_secded_decoder_pipe;

  localparam int DATA_W = 32;
  localparam int PAR_W  = 6;
  localparam int CNT_W  = 4;
  localparam int CW_W   = DATA_W + PAR_W + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              e1;
    logic              e2;
    logic [PAR_W:0]    pos;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   ddi = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] ddo;
  logic              e1;
  logic              e2;
  logic [PAR_W:0]    err_pos;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  ue_cnt;
`ifdef ECC_ERR_LOG_EN
  logic              log_valid;
  logic              log_type;
  logic [PAR_W:0]    log_synd;
`endif

  ecc_secded_decoder_pipe #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .ddi(ddi),
    .out_valid(out_valid), .out_ready(out_ready), .ddo(ddo), .e1(e1), .e2(e2),
    .err_pos(err_pos), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
`ifdef ECC_ERR_LOG_EN
    , .log_valid(log_valid), .log_type(log_type), .log_synd(log_synd)
`endif
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   ce_m = 0;
  int   ue_m = 0;
  logic lm_valid = 1'b0;
  logic lm_type = 1'b0;
  logic [PAR_W:0] lm_synd = '0;
  int   bp_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_pow2(input int i);
    return (i & (i - 1)) == 0;
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] cw;
    int j;
    int s;
    cw = '0;
    j  = 0;
    for (int i = 1; i < CW_W; i++) begin
      if (!is_pow2(i)) begin
        cw[i] = d[j];
        j++;
      end
    end
    s = 0;
    for (int i = 1; i < CW_W; i++) if (cw[i]) s = s ^ i;
    for (int k = 0; k < PAR_W; k++) cw[1 << k] = s[k];
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 1; i < CW_W; i++) begin
      if (!is_pow2(i)) begin
        d[j] = cw[i];
        j++;
      end
    end
    return d;
  endfunction

  // a/b are flipped codeword positions, -1 for none; b is only used with a.
  task automatic build(input logic [DATA_W-1:0] d, input int a, input int b,
                       output logic [CW_W-1:0] cw, output exp_t e,
                       output int kind, output logic [PAR_W:0] synd);
    cw = encode(d);
    if (a >= 0) cw[a] = ~cw[a];
    if (b >= 0) cw[b] = ~cw[b];
    e.d = d; e.e1 = 1'b0; e.e2 = 1'b0; e.pos = '0;
    kind = 0;
    synd = '0;
    if (a >= 0 && b < 0) begin
      e.e1 = 1'b1; e.pos = (PAR_W+1)'(a);
      kind = 1; synd = {1'b1, PAR_W'(a)};
    end else if (a >= 0) begin
      e.e2 = 1'b1; e.d = extract(cw);
      kind = 2; synd = {1'b0, PAR_W'(a ^ b)};
    end
  endtask

  task automatic send(input logic [CW_W-1:0] cw, input exp_t e, input int kind,
                      input logic [PAR_W:0] synd);
    bit ok;
    int guard;
    ok = 0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      in_valid = 1'b1;
      ddi = cw;
      #1 ok = in_ready;
      @(posedge clk);
      guard++;
    end
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
    else begin
      sbq.push_back(e);
      if (kind == 1 && ce_m < CMAX) ce_m++;
      if (kind == 2 && ue_m < CMAX) ue_m++;
      if (kind != 0 && !lm_valid) begin
        lm_valid = 1'b1; lm_type = (kind == 2); lm_synd = synd;
      end
    end
  endtask

  task automatic inject(input logic [DATA_W-1:0] d, input int a, input int b);
    logic [CW_W-1:0] cw;
    exp_t e;
    int kind;
    logic [PAR_W:0] synd;
    build(d, a, b, cw, e, kind, synd);
    send(cw, e, kind, synd);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    idle();
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk({tag, "_drain"}, 64'(sbq.size()), 64'd0);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ce"}, 64'(ce_cnt), 64'(ce_m));
    chk({tag, "_ue"}, 64'(ue_cnt), 64'(ue_m));
`ifdef ECC_ERR_LOG_EN
    chk({tag, "_log"}, 64'({log_valid, log_type, log_synd}), 64'({lm_valid, lm_type, lm_synd}));
`endif
  endtask

  // Output backpressure generator
  initial forever begin
    @(negedge clk);
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom % 4) != 0;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  initial begin
    logic held;
    logic [41:0] saved;
    exp_t e;
    held = 1'b0;
    saved = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) held = 1'b0;
      else begin
        if (held) chk("hold", 64'({out_valid, e1, e2, err_pos, ddo}), 64'(saved));
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
          else begin
            e = sbq.pop_front();
            chk("data", 64'({e1, e2, err_pos, ddo}), 64'({e.e1, e.e2, e.pos, e.d}));
          end
        end
        held  = out_valid && !out_ready;
        saved = {out_valid, e1, e2, err_pos, ddo};
      end
    end
  end

  initial begin
    logic [CW_W-1:0] cw;
    exp_t e;
    int kind;
    logic [PAR_W:0] synd;
    int a;
    int b;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", 64'({out_valid, e1, e2, err_pos, ddo}), 64'd0);
    chk_state("rst");
    rst_n = 1'b1;

    // Clean word, latency 2
    build(32'hDEADBEEF, -1, -1, cw, e, kind, synd);
    @(negedge clk);
    in_valid = 1'b1;
    ddi = cw;
    #1 chk("lat_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_cycle1", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk("lat_cycle2", 64'(out_valid), 64'd1);
    drain("t1");
    chk_state("t1");

    // Single errors: data bit position 5, then overall parity bit
    inject(32'h0000_0001, 5, -1);
    inject(32'h0000_0001, 0, -1);
    drain("t2");
    chk_state("t2");

    // Double error
    inject(32'hFFFF_FFFF, 3, 17);
    drain("t3");
    chk_state("t3");

    // Stall: S1 fills, in_ready must drop; then 6 more words
    bp_mode = 2;
    @(negedge clk);
    inject(32'h1111_0000, -1, -1);
    inject(32'h2222_0000, -1, -1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    bp_mode = 0;
    for (int i = 3; i <= 8; i++) inject(DATA_W'(i * 32'h1111_0000), -1, -1);
    drain("t4");

    // Saturation
    for (int i = 0; i < 20; i++) inject($urandom, 1 + (i % (CW_W - 1)), -1);
    drain("t5");
    chk_state("t5");

    // Random traffic with random backpressure
    bp_mode = 1;
    for (int i = 0; i < 200; i++) begin
      n = $urandom % 3;
      a = $urandom % CW_W;
      b = (a + 1 + ($urandom % (CW_W - 1))) % CW_W;
      inject($urandom, (n > 0) ? a : -1, (n > 1) ? b : -1);
      if ($urandom % 4 == 0) idle();
    end
    bp_mode = 0;
    drain("rand");
    chk_state("rand");

    // Clear coinciding with a single-error word entering S2
    build(32'hCAFE_F00D, 9, -1, cw, e, kind, synd);
    @(negedge clk);
    in_valid = 1'b1;
    ddi = cw;
    @(posedge clk);
    sbq.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    ce_m = 1;
    ue_m = 0;
    lm_valid = 1'b1; lm_type = 1'b0; lm_synd = synd;
    #1 chk_state("clr");
    drain("clr");

    // Asynchronous reset with both stages full
    bp_mode = 2;
    @(negedge clk);
    inject(32'h0BAD_0001, 4, -1);
    inject(32'h0BAD_0002, -1, -1);
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    sbq.delete();
    ce_m = 0;
    ue_m = 0;
    lm_valid = 1'b0; lm_type = 1'b0; lm_synd = '0;
    chk_state("arst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bp_mode = 0;
    @(negedge clk);
    #1 chk("arst_in_ready", 64'(in_ready), 64'd1);

    // Two errors after reset: the log keeps the first
    inject(32'h1234_5678, 7, -1);
    inject(32'h8765_4321, 2, 30);
    drain("post");
    chk_state("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
